mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS32 pipeline EX stage; implements MULT, MULTU, DIV, DIVU, MTHI, MTLO and exposes HI/LO for MFHI/MFLO.
- Multi-cycle, radix-2 (one bit per cycle); raises `busy` so the hazard logic can stall dependent MFHI/MFLO; supports abort on pipeline flush, e.g. when a branch is taken.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; legal values are >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; honoured only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  input  WIDTH  rs operand (multiplicand / dividend); sampled with start.
- b  input  WIDTH  rt operand (multiplier / divisor); sampled with start.
- flush  input  1  abort the operation in flight.
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse: HI/LO were just updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: the unit enters IDLE. busy=0, done=0, hi=0, lo=0, all internal registers 0. Reset at any time, including mid-operation, overrides everything.
- FSM states are IDLE, RUN, FIX.
- IDLE -> RUN on an edge with start=1 and flush=0.
  - On that edge, op is latched and the operand magnitudes are captured (|a| and |b| for signed ops, raw values for unsigned).
  - The result sign flags are captured: product sign = a[MSB]^b[MSB]; quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB]. The flags are 0 for unsigned ops.
  - The counter is loaded with WIDTH.
- RUN: one iteration per edge; the counter decrements each iteration.
  - Multiply uses shift-add on a 2*WIDTH accumulator.
  - Divide uses restoring division: a WIDTH+1-bit partial remainder and a WIDTH-bit quotient.
  - After the WIDTH-th iteration, the state goes to FIX.
- FIX: one edge applies the sign correction (two's complement negate of flagged results), writes hi and lo, sets done=1 and returns to IDLE.
  - Multiply: {hi,lo} = 2*WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder.
- Latency: with start accepted at edge 0, new hi/lo and done=1 are visible after edge WIDTH+1.
  - busy=1 after edges 1..WIDTH; busy=0 again when done=1.
  - done is high for exactly one cycle.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- DIV of the most negative value by -1: lo = most negative value, hi = 0. This falls out of the magnitude arithmetic modulo 2^WIDTH.
- Divide by zero (b=0), DIV or DIVU: lo = all ones, hi = a unchanged. No sign correction is applied and no exception is raised.
- start while busy: ignored; no queuing, and the in-flight operation is unaffected.
- flush while busy (RUN or FIX): IDLE on the next edge; hi/lo keep their pre-operation values; done stays 0.
- flush in IDLE: no effect, except that it blocks a simultaneous start.
- hi_we/lo_we in IDLE with start=0: hi/lo take wdata on that edge; both may be written in the same cycle.
- hi_we/lo_we while busy, or in the same cycle as an accepted start: ignored.
- hi/lo are directly registered outputs with no combinational path from the inputs.

Test Plan (WIDTH=32):
- MULT with a=0xFFFFFFFD (-3), b=7 -> after edge 33: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for one cycle; busy=1 after edges 1..32.
- MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT with a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=100, b=7 -> lo=14, hi=2.
- DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU with a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- Abort and back-to-back:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then start MULTU 5*6.
  - Pulse flush at edge 10 -> busy=0 next cycle, no done, hi=0x11, lo=0x22.
  - A second start at edge 5 of another operation is ignored.
  - A new start in IDLE completes normally with hi=0, lo=30.
- Reset and write priority:
  - Assert reset at edge 20 of a DIVU -> busy=0, done=0, hi=lo=0 next cycle.
  - hi_we with start in the same IDLE cycle -> the write is dropped and hi is only the later result.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the MIPS32 EX stage.
// Sign handling works on magnitudes and applies one two's-complement fix-up after the last iteration.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_next;

    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               accept;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = (state == IDLE) && start && !flush;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign div_zero  = op[1] && (b == '0);

    // Multiply: acc_lo starts as the multiplier and fills with product bits as it shifts out.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b};
    assign div_diff  = div_shift[WIDTH-1:0] - mag_b;

    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = neg_main ? -prod : prod;
    assign quo_fix   = neg_main ? -acc_lo : acc_lo;
    assign rem_fix   = neg_rem ? -acc_hi : acc_hi;

    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN: begin
                if (flush)
                    state_next = IDLE;
                else if (cnt == CNT_W'(1))
                    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divide by zero loads the raw dividend with no sign flags so the remainder comes out as a.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            mag_b    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= op[1];
                        cnt    <= CNT_W'(WIDTH);
                        acc_hi <= '0;
                        if (op[1]) begin
                            acc_lo   <= div_zero ? a : a_mag;
                            mag_b    <= b_mag;
                            neg_main <= ~div_zero & (a_neg ^ b_neg);
                            neg_rem  <= ~div_zero & a_neg;
                        end else begin
                            acc_lo   <= b_mag;
                            mag_b    <= a_mag;
                            neg_main <= a_neg ^ b_neg;
                            neg_rem  <= 1'b0;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        cnt <= cnt - CNT_W'(1);
                        if (is_div) begin
                            acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed cases plus randomized ops against a 64-bit arithmetic model.
module tb_mips_muldiv_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              flush;
    logic              hi_we;
    logic              lo_we;
    logic [WIDTH-1:0]  wdata;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int n_checks = 0;
    int n_fail   = 0;

    mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference results from plain 64-bit arithmetic (SV division truncates toward zero).
    function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pu;
        case (mop)
            2'b00: begin p = longint'($signed(ma)) * longint'($signed(mb)); {mhi, mlo} = p; end
            2'b01: begin pu = {32'b0, ma} * {32'b0, mb}; {mhi, mlo} = pu; end
            default: begin
                if (mb == 32'd0) begin
                    mlo = 32'hFFFF_FFFF;
                    mhi = ma;
                end else if (mop == 2'b10) begin
                    q = longint'($signed(ma)) / longint'($signed(mb));
                    r = longint'($signed(ma)) % longint'($signed(mb));
                    mlo = q[31:0];
                    mhi = r[31:0];
                end else begin
                    mlo = ma / mb;
                    mhi = ma % mb;
                end
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] lop, input logic [31:0] la, input logic [31:0] lb);
        @(negedge clk);
        start = 1'b1; op = lop; a = la; b = lb;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] data);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = data;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Waits for done; cycles counts edges after the accepting edge.
    task automatic wait_done(output int cycles, output bit seen, output bit busy_dropped);
        cycles = 0; seen = 1'b0; busy_dropped = 1'b0;
        while (!seen && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
            else if (!busy) busy_dropped = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; op = 0; a = 0; b = 0; flush = 0; hi_we = 0; lo_we = 0; wdata = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b0;
    endtask

    task automatic test_mult_timing();
        int cycles; bit seen; bit dropped;
        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mult_busy_start: got %b expected 1", busy); end
        wait_done(cycles, seen, dropped);
        n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL mult_timeout: done never seen after %0d cycles", cycles); end
        n_checks++; if (cycles != WIDTH + 1) begin n_fail++; $display("[TB] FAIL mult_latency: got %0d expected %0d", cycles, WIDTH + 1); end
        n_checks++; if (dropped) begin n_fail++; $display("[TB] FAIL mult_busy_run: busy low before done, got 1 expected 0"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mult_busy_done: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("[TB] FAIL mult_neg_lo: got %h expected ffffffeb", lo); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd100};
        logic [31:0] bs  [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ehi [6] = '{32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h64};
        logic [31:0] elo [6] = '{32'h1, 32'h0, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF};
        int cycles; bit seen; bit dropped;
        for (int i = 0; i < 6; i++) begin
            launch(ops[i], as[i], bs[i]);
            wait_done(cycles, seen, dropped);
            n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL directed_%0d_timeout: done never seen", i); end
            n_checks++; if (hi !== ehi[i]) begin n_fail++; $display("[TB] FAIL directed_%0d_hi: got %h expected %h", i, hi, ehi[i]); end
            n_checks++; if (lo !== elo[i]) begin n_fail++; $display("[TB] FAIL directed_%0d_lo: got %h expected %h", i, lo, elo[i]); end
        end
    endtask

    task automatic test_mthi_mtlo();
        write_hilo(1'b1, 1'b0, 32'h1234_5678);
        write_hilo(1'b0, 1'b1, 32'h9ABC_DEF0);
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL mthi: got %h expected 12345678", hi); end
        n_checks++; if (lo !== 32'h9ABC_DEF0) begin n_fail++; $display("[TB] FAIL mtlo: got %h expected 9abcdef0", lo); end
        write_hilo(1'b1, 1'b1, 32'h0BAD_F00D);
        n_checks++; if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D)
            begin n_fail++; $display("[TB] FAIL mthi_mtlo_both: got %h/%h expected 0badf00d/0badf00d", hi, lo); end
    endtask

    task automatic test_abort();
        int cycles; bit seen; bit dropped;
        logic [31:0] ehi, elo;
        write_hilo(1'b1, 1'b0, 32'h11);
        write_hilo(1'b0, 1'b1, 32'h22);
        launch(2'b01, 32'd5, 32'd6);
        for (int i = 1; i < 5; i++) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7; hi_we = 1'b1; wdata = 32'h99;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        n_checks++; if (busy !== 1'b1 || hi !== 32'h11) begin n_fail++; $display("[TB] FAIL abort_busy_write: got busy=%b hi=%h expected 1/00000011", busy, hi); end
        for (int i = 6; i < 10; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        seen = 1'b0;
        repeat (40) begin if (done) seen = 1'b1; @(negedge clk); end
        n_checks++; if (seen) begin n_fail++; $display("[TB] FAIL abort_done: got 1 expected 0"); end
        n_checks++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("[TB] FAIL abort_hilo: got %h/%h expected 00000011/00000022", hi, lo); end
        launch(2'b01, 32'd5, 32'd6);
        wait_done(cycles, seen, dropped);
        n_checks++; if (!seen || hi !== 32'd0 || lo !== 32'd30) begin n_fail++; $display("[TB] FAIL after_abort: got seen=%b %h/%h expected 1 00000000/0000001e", seen, hi, lo); end
        launch(2'b00, 32'd9, 32'hFFFF_FFFE);
        for (int i = 1; i < 5; i++) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(cycles, seen, dropped);
        model(2'b00, 32'd9, 32'hFFFF_FFFE, ehi, elo);
        n_checks++; if (!seen || cycles != WIDTH - 4 || hi !== ehi || lo !== elo)
            begin n_fail++; $display("[TB] FAIL start_while_busy: got seen=%b cyc=%0d %h/%h expected 1 %0d %h/%h", seen, cycles, hi, lo, WIDTH - 4, ehi, elo); end
    endtask

    task automatic test_reset_mid();
        write_hilo(1'b1, 1'b1, 32'hAA);
        launch(2'b11, 32'd1000, 32'd3);
        for (int i = 1; i < 20; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid_ctl: got busy=%b done=%b expected 0/0", busy, done); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_mid_hilo: got %h/%h expected 0/0", hi, lo); end
    endtask

    task automatic test_priority();
        int cycles; bit seen; bit dropped;
        write_hilo(1'b1, 1'b1, 32'h55);
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_blocks_start: got busy=%b expected 0", busy); end
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n_checks++; if (hi !== 32'h55 || lo !== 32'h55) begin n_fail++; $display("[TB] FAIL write_with_start: got %h/%h expected 00000055/00000055", hi, lo); end
        wait_done(cycles, seen, dropped);
        n_checks++; if (!seen || hi !== 32'd0 || lo !== 32'd12) begin n_fail++; $display("[TB] FAIL priority_result: got seen=%b %h/%h expected 1 0/0000000c", seen, hi, lo); end
    endtask

    task automatic test_back_to_back();
        int cycles; bit seen; bit dropped;
        logic [1:0]  rop;
        logic [31:0] ra, rb, ehi, elo;
        rop = 2'($urandom); ra = $urandom; rb = $urandom;
        launch(rop, ra, rb);
        for (int i = 0; i < 40; i++) begin
            wait_done(cycles, seen, dropped);
            model(rop, ra, rb, ehi, elo);
            n_checks++;
            if (!seen || dropped || hi !== ehi || lo !== elo)
                begin n_fail++; $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got seen=%b drop=%b %h/%h expected %h/%h", i, rop, ra, rb, seen, dropped, hi, lo, ehi, elo); end
            rop = 2'($urandom);
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                default: ;
            endcase
            start = 1'b1; op = rop; a = ra; b = rb;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(cycles, seen, dropped);
    endtask

    initial begin
        test_reset();
        test_mult_timing();
        test_directed();
        test_mthi_mtlo();
        test_abort();
        test_reset_mid();
        test_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
